// File: rtl/phy_boot_ctrl.sv
// PHY power-up sequencer: holds the PHY in reset with straps driven, waits for
// link, then releases the Tx/Rx datapath. Retries on timeout, re-inits on drop.
module phy_boot_ctrl #(
  parameter int unsigned        STRAP_W          = 5,
  parameter logic [STRAP_W-1:0] STRAP_VALUE      = 5'b10000,
  parameter int unsigned        RESET_CYCLES     = 100,
  parameter int unsigned        HOLD_CYCLES      = 20,
  parameter int unsigned        LINK_TIMEOUT     = 30000,
  parameter int unsigned        LINK_DROP_CYCLES = 50,
  parameter int unsigned        MAX_RETRY        = 3
) (
  input  logic               init_clk,
  input  logic               reset,
  input  logic               soft_rst,
  input  logic               phy_linksts,
  output logic               phy_reset_n,
  output logic               strap_oe,
  output logic [STRAP_W-1:0] strap_val,
  output logic               datapath_rst,
  output logic               ready,
  output logic               fail,
  output logic [3:0]         retry_cnt,
  output logic [2:0]         state
);

  localparam int unsigned MAX_RH  = (RESET_CYCLES > HOLD_CYCLES) ? RESET_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_RH > LINK_TIMEOUT) ? MAX_RH : LINK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned DROP_W  = $clog2(LINK_DROP_CYCLES + 1);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(LINK_DROP_CYCLES - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_HOLD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READY = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [DROP_W-1:0]  drop_d, drop_q;
  logic [3:0]         retry_d, retry_q;
  logic               link_p0_d, link_p0_q;
  logic               link_p1_d, link_p1_q;
  logic               link_s;
  logic               phy_reset_n_d, phy_reset_n_q;
  logic               strap_oe_d, strap_oe_q;
  logic               datapath_rst_d, datapath_rst_q;
  logic               ready_d, ready_q;
  logic               fail_d, fail_q;

  // Two-flop synchroniser for the asynchronous link status
  always_comb begin
    link_p0_d = phy_linksts;
    link_p1_d = link_p0_q;
  end

  assign link_s = link_p1_q;

  // Next-state: soft_rst overrides every timeout/link/drop event
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    drop_d  = '0;
    retry_d = retry_q;
    if (soft_rst) begin
      state_d = ST_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          if (link_s) begin
            state_d = ST_READY;
            cnt_d   = '0;
            retry_d = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              state_d = ST_RST;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_READY: begin
          cnt_d = '0;
          if (!link_s) begin
            if (drop_q == DROP_LAST) begin
              state_d = ST_RST;
            end else begin
              drop_d = drop_q + DROP_W'(1);
            end
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the next state so they move with state_q
  always_comb begin
    phy_reset_n_d  = (state_d == ST_HOLD) || (state_d == ST_WAIT) || (state_d == ST_READY);
    strap_oe_d     = (state_d == ST_RST) || (state_d == ST_HOLD) || (state_d == ST_FAIL);
    datapath_rst_d = (state_d != ST_READY);
    ready_d        = (state_d == ST_READY);
    fail_d         = (state_d == ST_FAIL);
  end

  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RST;
      cnt_q          <= '0;
      drop_q         <= '0;
      retry_q        <= '0;
      link_p0_q      <= 1'b0;
      link_p1_q      <= 1'b0;
      phy_reset_n_q  <= 1'b0;
      strap_oe_q     <= 1'b1;
      datapath_rst_q <= 1'b1;
      ready_q        <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      drop_q         <= drop_d;
      retry_q        <= retry_d;
      link_p0_q      <= link_p0_d;
      link_p1_q      <= link_p1_d;
      phy_reset_n_q  <= phy_reset_n_d;
      strap_oe_q     <= strap_oe_d;
      datapath_rst_q <= datapath_rst_d;
      ready_q        <= ready_d;
      fail_q         <= fail_d;
    end
  end

  assign phy_reset_n  = phy_reset_n_q;
  assign strap_oe     = strap_oe_q;
  assign strap_val    = STRAP_VALUE;
  assign datapath_rst = datapath_rst_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign retry_cnt    = retry_q;
  assign state        = state_q;

endmodule

// File: tb/tb_phy_boot_ctrl.sv
// Bench for phy_boot_ctrl: directed boot scenarios plus randomized link/soft_rst/reset
// traffic, all compared every cycle against a phase/elapsed-time reference model.
module tb_phy_boot_ctrl;

  localparam int unsigned    RC = 4;
  localparam int unsigned    HC = 2;
  localparam int unsigned    TO = 8;
  localparam int unsigned    DC = 3;
  localparam int unsigned    MR = 2;
  localparam int unsigned    SW = 5;
  localparam logic [SW-1:0]  SV = 5'b10000;

  logic          init_clk = 1'b0;
  logic          reset;
  logic          soft_rst;
  logic          phy_linksts;
  logic          phy_reset_n;
  logic          strap_oe;
  logic [SW-1:0] strap_val;
  logic          datapath_rst;
  logic          ready;
  logic          fail;
  logic [3:0]    retry_cnt;
  logic [2:0]    state;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  // Reference model: phase numbers follow the published state encoding,
  // m_elapsed counts whole cycles spent in the current phase.
  int m_phase, m_elapsed, m_retry, m_low;
  bit m_s1, m_s2;

  phy_boot_ctrl #(
    .STRAP_W(SW), .STRAP_VALUE(SV), .RESET_CYCLES(RC), .HOLD_CYCLES(HC),
    .LINK_TIMEOUT(TO), .LINK_DROP_CYCLES(DC), .MAX_RETRY(MR)
  ) dut (
    .init_clk(init_clk), .reset(reset), .soft_rst(soft_rst), .phy_linksts(phy_linksts),
    .phy_reset_n(phy_reset_n), .strap_oe(strap_oe), .strap_val(strap_val),
    .datapath_rst(datapath_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 init_clk = ~init_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_phase = 0; m_elapsed = 0; m_retry = 0; m_low = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic m_enter(input int p);
    m_phase = p; m_elapsed = 0; m_low = 0;
  endtask

  task automatic m_step();
    bit ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = phy_linksts;
    m_elapsed++;
    if (soft_rst) begin
      m_retry = 0;
      m_enter(0);
    end else begin
      case (m_phase)
        0: if (m_elapsed >= RC) m_enter(1);
        1: if (m_elapsed >= HC) m_enter(2);
        2: begin
          if (ls) begin
            m_retry = 0;
            m_enter(3);
          end else if (m_elapsed >= TO) begin
            if (m_retry < MR) begin
              m_retry++;
              m_enter(0);
            end else begin
              m_enter(4);
            end
          end
        end
        3: begin
          m_low = ls ? 0 : m_low + 1;
          if (m_low >= DC) m_enter(0);
        end
        default: ;
      endcase
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".state"},  32'(state),        32'(m_phase));
    chk({tag, ".prst_n"}, 32'(phy_reset_n),  (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
    chk({tag, ".oe"},     32'(strap_oe),     (m_phase == 0 || m_phase == 1 || m_phase == 4) ? 1 : 0);
    chk({tag, ".dprst"},  32'(datapath_rst), (m_phase != 3) ? 1 : 0);
    chk({tag, ".ready"},  32'(ready),        (m_phase == 3) ? 1 : 0);
    chk({tag, ".fail"},   32'(fail),         (m_phase == 4) ? 1 : 0);
    chk({tag, ".retry"},  32'(retry_cnt),    32'(m_retry));
    chk({tag, ".strap"},  32'(strap_val),    32'(SV));
  endtask

  // Inputs change only at the falling edge; the model steps on the rising edge.
  task automatic tick(input string tag);
    @(posedge init_clk);
    if (reset) m_reset();
    else m_step();
    @(negedge init_clk);
    cmp_all(tag);
  endtask

  task automatic do_reset(input logic link);
    reset = 1'b1;
    soft_rst = 1'b0;
    m_reset();
    #1 cmp_all("rst_async");
    tick("rst_hold");
    phy_linksts = link;
    reset = 1'b0;
    cmp_all("rst_rel");
  endtask

  // sel 0 waits for ready, sel 1 for fail; returns -1 when the budget runs out
  task automatic wait_for(input int sel, input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      tick("wait");
      if ((sel == 0 && ready === 1'b1) || (sel == 1 && fail === 1'b1)) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    int mode;
    reset = 1'b1; soft_rst = 1'b0; phy_linksts = 1'b0;
    m_reset();
    #1 cmp_all("por");
    tick("por");
    tick("por");

    // Boot with link up from the start
    phy_linksts = 1'b1;
    reset = 1'b0;
    cmp_all("t1_rel");
    wait_for(0, 40, n);
    chk("t1_ready_lat", n, 7);

    // Two-cycle glitch is ignored, three-cycle drop re-initialises
    phy_linksts = 1'b0;
    tick("t4_glitch"); tick("t4_glitch");
    phy_linksts = 1'b1;
    repeat (6) tick("t4_glitch");
    chk("t4_glitch_ready", ready, 1);
    phy_linksts = 1'b0;
    tick("t4_drop"); tick("t4_drop"); tick("t4_drop");
    phy_linksts = 1'b1;
    tick("t4_drop"); tick("t4_drop");
    chk("t4_drop_state", state, 0);
    chk("t4_drop_dprst", datapath_rst, 1);
    chk("t4_drop_retry", retry_cnt, 0);

    // No link ever: three attempts then FAIL
    do_reset(1'b0);
    wait_for(1, 100, n);
    chk("t2_fail_lat", n, 42);
    chk("t2_fail_retry", retry_cnt, 2);
    chk("t2_fail_prst_n", phy_reset_n, 0);
    repeat (5) tick("t2_hold");

    // soft_rst out of FAIL with link present
    phy_linksts = 1'b1;
    soft_rst = 1'b1;
    tick("t3_soft");
    soft_rst = 1'b0;
    chk("t3_fail_clr", fail, 0);
    chk("t3_retry_clr", retry_cnt, 0);
    wait_for(0, 40, n);
    chk("t3_ready_lat", n + 1, 8);

    // Link arrives exactly at the timeout edge
    do_reset(1'b0);
    repeat (11) tick("t5_link");
    phy_linksts = 1'b1;
    repeat (3) tick("t5_link");
    chk("t5_link_wins", state, 3);
    chk("t5_link_retry", retry_cnt, 0);

    // soft_rst coincident with the timeout edge
    do_reset(1'b0);
    repeat (13) tick("t5_soft");
    soft_rst = 1'b1;
    tick("t5_soft");
    soft_rst = 1'b0;
    chk("t5_soft_state", state, 0);
    chk("t5_soft_retry", retry_cnt, 0);

    // Asynchronous reset in the middle of HOLD
    do_reset(1'b1);
    repeat (4) tick("t6_pre");
    chk("t6_in_hold", state, 1);
    #2 reset = 1'b1;
    m_reset();
    #1 cmp_all("t6_async");
    chk("t6_async_prst_n", phy_reset_n, 0);
    tick("t6_held");
    reset = 1'b0;
    repeat (3) tick("t6_rst");
    chk("t6_rst_prst_n", phy_reset_n, 0);
    tick("t6_rst");
    chk("t6_back_hold", state, 1);

    // Randomized link traffic with occasional soft_rst and reset
    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 128 == 0) mode = int'($urandom_range(2));
      case (mode)
        0:       phy_linksts = ($urandom_range(19) == 0);
        1:       if ($urandom_range(5) == 0) phy_linksts = ~phy_linksts;
        default: phy_linksts = ($urandom_range(9) != 0);
      endcase
      soft_rst = ($urandom_range(59) == 0);
      reset = ($urandom_range(249) == 0);
      if (reset) m_reset();
      tick("rnd");
    end
    reset = 1'b0;
    soft_rst = 1'b0;
    tick("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
